mem_wb_writeback: RTL and testbench
===================================

# mem_wb_writeback

Write-back stage and register file sitting at the consumer end of the MEM/WB pipeline latch. Takes the latched write-back controls, memory read data, ALU result and destination register, selects the write-back value, and commits it to a 32×32-bit MIPS register file. Also serves the ID stage's two asynchronous read ports. A build-time option adds same-cycle write-through bypass on those read ports.

## Interface
- Parameters: none; the register file is fixed at 32 entries × 32 bits.
- clk  in  1  rising-edge system clock.
- rst_n  in  1  synchronous, active-low reset.
- mem_control_wb  in  2  latched WB controls: bit 1 = RegWrite, bit 0 = MemtoReg.
- Read_data  in  32  latched data-memory read value.
- mem_ALU_result  in  32  latched ALU result.
- mem_Write_reg  in  5  latched destination register number.
- rs_addr  in  5  ID-stage read port A address.
- rt_addr  in  5  ID-stage read port B address.
- rs_data  out  32  read port A data (combinational).
- rt_data  out  32  read port B data (combinational).
- wb_data  out  32  selected write-back value (combinational), exported to the forwarding unit.
- wb_reg_write  out  1  effective write enable: RegWrite & rst_n & (mem_Write_reg != 0).
- wb_write_reg  out  5  echo of mem_Write_reg.
- retire_count  out  32  count of cycles that retired a register write.

## Operation
- wb_data = MemtoReg ? Read_data : mem_ALU_result. This select is purely combinational.
- Commit: on a rising clk edge with rst_n=1, RegWrite=1 and mem_Write_reg≠0, regs[mem_Write_reg] ← wb_data.
- Register $0 is hardwired to zero.
  - A write to $0 is discarded.
  - A read of $0 always returns 32'h0, including when bypass is enabled.
- Read ports are asynchronous: rs_data = regs[rs_addr] and rt_data = regs[rt_addr], each subject to the bypass rule under Configuration.
- retire_count increments by 1 on each rising edge with rst_n=1 and RegWrite=1.
  - It counts writes to $0 too, because it counts retired write instructions, not file updates.
  - It wraps from 32'hFFFFFFFF to 0 with no flag.
- Reset: on any rising edge with rst_n=0, all 32 registers and retire_count clear to 0. Writes and counting are suppressed on that edge.
- Output values while rst_n=0:
  - wb_reg_write = 0.
  - rs_data and rt_data show array contents, which are all 0 from the first reset edge onward.
  - wb_data and wb_write_reg continue to follow their inputs.
- Reset asserted mid-stream aborts the write presented on that edge. No partial state is left behind.

## Timing
- Write latency: data presented in cycle N is visible in the array after the rising edge ending cycle N.
- Read latency: zero cycles, combinational from address to data.
- Without bypass, a same-cycle read of the register being written returns the old value. The new value appears after the edge.
- With bypass, a same-cycle read of the register being written returns wb_data in that same cycle.
- Both read ports may address the write target at once; both receive the same value.
- X or undriven mem_control_wb during reset must not corrupt state.

## Configuration
- Macro: WB_BYPASS_EN.
- Defined:
  - When wb_reg_write=1 and rs_addr==mem_Write_reg, rs_data = wb_data.
  - The same rule applies to rt_addr and rt_data.
  - This gives write-then-read in the same cycle and removes the split-cycle register-file requirement.
- Undefined:
  - No bypass mux is built; reads return array contents only.
  - The hazard unit must then stall one extra cycle on a WB→ID dependency.
- retire_count, $0 handling and reset behaviour are identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 2 edges with RegWrite=1, mem_Write_reg=3 -> retire_count=0, rs_addr=3 reads 0, wb_reg_write=0.
- ALU write-back:
  - Stimulus: control=2'b10, mem_ALU_result=32'h00ADAD10, mem_Write_reg=3, for one edge.
  - Required: next cycle rs_addr=3 reads 32'h00ADAD10 and retire_count=1.
- Load write-back:
  - Stimulus: control=2'b11, Read_data=32'hFF00AAD0, mem_Write_reg=31.
  - Required: rt_addr=31 reads 32'hFF00AAD0 after the edge.
- Control=2'b01 and $0:
  - control=2'b01 (no RegWrite) with mem_Write_reg=5 -> regs[5] unchanged and count unchanged.
  - control=2'b10 with mem_Write_reg=0 and value 32'h12345678 -> rs_addr=0 reads 0 and count increments.
- Same-cycle read of the write target: write 32'hCAFEF00D to reg 7 while rs_addr=rt_addr=7.
  - With WB_BYPASS_EN: both ports read CAFEF00D before the edge.
  - Without it: both read the prior value, 0.
- Wrap and mid-run reset:
  - Stimulus: force retire_count to 32'hFFFFFFFF via writes, then one more write.
  - Required: retire_count reads 0.
  - Then assert rst_n=0 on an edge carrying a write to reg 9 -> reg 9 reads 0 and count reads 0.

Source files
------------

// File: rtl/mem_wb_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_writeback_if
// Description : Bundle of MEM/WB latch outputs, ID-stage read ports and
//               write-back results seen by the write-back / register file.
//   mem_control_wb [1:0] : bit 1 RegWrite, bit 0 MemtoReg
//   Read_data      [31:0]: latched data-memory read value
//   mem_ALU_result [31:0]: latched ALU result
//   mem_Write_reg  [4:0] : latched destination register
//   rs_addr/rt_addr[4:0] : ID-stage read addresses
//   rs_data/rt_data[31:0]: combinational read data
//   wb_data        [31:0]: selected write-back value
//   wb_reg_write         : effective write enable
//   wb_write_reg   [4:0] : echo of mem_Write_reg
//   retire_count   [31:0]: retired register-write count
//   slave  : register file side
//   master : pipeline / test driver side
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_writeback_if;
  logic [1:0]  mem_control_wb;
  logic [31:0] Read_data;
  logic [31:0] mem_ALU_result;
  logic [4:0]  mem_Write_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] retire_count;

  modport slave (
    input  mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_reg_write, wb_write_reg, retire_count
  );

  modport master (
    output mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_reg_write, wb_write_reg, retire_count
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_writeback
// Description : MIPS write-back stage plus 32x32 register file. Selects the
//               write-back value, commits it on the rising clock edge and
//               serves two asynchronous read ports. Counts cycles that retire
//               a register write (including writes aimed at $0).
// Ports       :
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears registers and counter)
//   bus   : mem_wb_writeback_if.slave (see interface header)
// Build option: define WB_BYPASS_EN to forward wb_data onto a read port
//               that addresses the register being written in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_writeback (
  input wire clk,
  input wire rst_n,
  mem_wb_writeback_if.slave bus
);

  logic [31:0] r_regs [32];
  logic [31:0] r_retire_count;

  logic        w_reg_write_req;
  logic        w_mem_to_reg;
  logic        w_wb_we;
  logic [31:0] w_wb_data;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  assign w_reg_write_req = bus.mem_control_wb[1];
  assign w_mem_to_reg    = bus.mem_control_wb[0];
  assign w_wb_data       = w_mem_to_reg ? bus.Read_data : bus.mem_ALU_result;
  // rst_n gates the enable so an X control during reset still yields 0.
  assign w_wb_we         = rst_n & w_reg_write_req & (bus.mem_Write_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0;
      end
      r_retire_count <= 32'h0;
    end else begin
      if (w_wb_we) begin
        r_regs[bus.mem_Write_reg] <= w_wb_data;
      end
      // Counts retired write instructions, so $0 targets still count.
      if (w_reg_write_req) begin
        r_retire_count <= r_retire_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_rs_data = r_regs[bus.rs_addr];
    w_rt_data = r_regs[bus.rt_addr];
`ifdef WB_BYPASS_EN
    if (w_wb_we && (bus.rs_addr == bus.mem_Write_reg)) begin
      w_rs_data = w_wb_data;
    end
    if (w_wb_we && (bus.rt_addr == bus.mem_Write_reg)) begin
      w_rt_data = w_wb_data;
    end
`endif
    // $0 reads zero even before the first reset edge has cleared the array.
    if (bus.rs_addr == 5'd0) begin
      w_rs_data = 32'h0;
    end
    if (bus.rt_addr == 5'd0) begin
      w_rt_data = 32'h0;
    end
  end

  assign bus.rs_data      = w_rs_data;
  assign bus.rt_data      = w_rt_data;
  assign bus.wb_data      = w_wb_data;
  assign bus.wb_reg_write = w_wb_we;
  assign bus.wb_write_reg = bus.mem_Write_reg;
  assign bus.retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_writeback
// Description : Self-checking bench for mem_wb_writeback. Directed steps
//               followed by randomized traffic compared against a simple
//               array/counter reference model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_writeback;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  mem_wb_writeback_if bus ();

  mem_wb_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic [31:0] wb,
                                           input logic we, input logic [4:0] wr);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && a == wr) return wb;
`endif
    return m_regs[a];
  endfunction

  // Apply inputs, optionally check all combinational outputs against the
  // model, then clock one edge and update the model.
  task automatic step(input logic rstn, input logic [1:0] ctrl, input logic [31:0] rd,
                      input logic [31:0] alu, input logic [4:0] wr,
                      input logic [4:0] rs, input logic [4:0] rt, input bit chk);
    logic [31:0] wb;
    logic        we;
    rst_n              = rstn;
    bus.mem_control_wb = ctrl;
    bus.Read_data      = rd;
    bus.mem_ALU_result = alu;
    bus.mem_Write_reg  = wr;
    bus.rs_addr        = rs;
    bus.rt_addr        = rt;
    #1;
    wb = ctrl[0] ? rd : alu;
    we = rstn && ctrl[1] && (wr != 5'd0);
    if (chk) begin
      check("wb_data",      bus.wb_data, wb);
      check("wb_reg_write", {31'h0, bus.wb_reg_write}, {31'h0, we});
      check("wb_write_reg", {27'h0, bus.wb_write_reg}, {27'h0, wr});
      check("rs_data",      bus.rs_data, exp_read(rs, wb, we, wr));
      check("rt_data",      bus.rt_data, exp_read(rt, wb, we, wr));
      check("retire_count", bus.retire_count, m_count);
    end
    @(posedge clk);
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_count = 32'h0;
    end else begin
      if (ctrl[1]) m_count = m_count + 32'd1;
      if (we) m_regs[wr] = wb;
    end
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_count  = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    rst_n = 1'b0;
    bus.mem_control_wb = 2'b10;
    bus.Read_data = 32'h0;
    bus.mem_ALU_result = 32'h0;
    bus.mem_Write_reg = 5'd0;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    @(posedge clk);
    #1;

    // Reset with X controls, then reset with a write presented to reg 3.
    step(1'b0, 2'bxx, 32'h1, 32'h2, 5'd3, 5'd3, 5'd3, 1'b0);
    step(1'b0, 2'b10, 32'h0, 32'h55, 5'd3, 5'd3, 5'd3, 1'b0);
    step(1'b0, 2'b10, 32'h0, 32'h55, 5'd3, 5'd3, 5'd3, 1'b1);
    check("rst_count", bus.retire_count, 32'h0);
    check("rst_rs3", bus.rs_data, 32'h0);
    check("rst_we", {31'h0, bus.wb_reg_write}, 32'h0);

    // ALU write-back to reg 3.
    step(1'b1, 2'b10, 32'hDEAD0000, 32'h00ADAD10, 5'd3, 5'd3, 5'd0, 1'b1);
    step(1'b1, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0, 1'b1);
    check("alu_rs3", bus.rs_data, 32'h00ADAD10);
    check("alu_count", bus.retire_count, 32'd1);

    // Load write-back to reg 31.
    step(1'b1, 2'b11, 32'hFF00AAD0, 32'h1111, 5'd31, 5'd0, 5'd31, 1'b1);
    bus.mem_control_wb = 2'b00;
    #1;
    check("load_rt31", bus.rt_data, 32'hFF00AAD0);
    check("load_count", bus.retire_count, 32'd2);

    // MemtoReg without RegWrite: no update, no count.
    step(1'b1, 2'b01, 32'h77777777, 32'h0, 5'd5, 5'd5, 5'd5, 1'b1);
    check("norw_rs5", bus.rs_data, 32'h0);
    check("norw_count", bus.retire_count, 32'd2);

    // Write to $0: discarded but counted.
    step(1'b1, 2'b10, 32'h0, 32'h12345678, 5'd0, 5'd0, 5'd0, 1'b1);
    check("r0_rs", bus.rs_data, 32'h0);
    check("r0_count", bus.retire_count, 32'd3);

    // Same-cycle read of the write target.
    rst_n = 1'b1;
    bus.mem_control_wb = 2'b10;
    bus.mem_ALU_result = 32'hCAFEF00D;
    bus.mem_Write_reg = 5'd7;
    bus.rs_addr = 5'd7;
    bus.rt_addr = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("same_rs7", bus.rs_data, 32'hCAFEF00D);
    check("same_rt7", bus.rt_data, 32'hCAFEF00D);
`else
    check("same_rs7", bus.rs_data, 32'h0);
    check("same_rt7", bus.rt_data, 32'h0);
`endif
    step(1'b1, 2'b10, 32'h0, 32'hCAFEF00D, 5'd7, 5'd7, 5'd7, 1'b1);
    bus.mem_control_wb = 2'b00;
    #1;
    check("after_rs7", bus.rs_data, 32'hCAFEF00D);

    // Counter wrap: preload near the top, then two counted writes.
    force dut.r_retire_count = 32'hFFFFFFFE;
    #1;
    release dut.r_retire_count;
    m_count = 32'hFFFFFFFE;
    step(1'b1, 2'b10, 32'h0, 32'hA5A5A5A5, 5'd4, 5'd4, 5'd4, 1'b1);
    check("wrap_ff", bus.retire_count, 32'hFFFFFFFF);
    step(1'b1, 2'b10, 32'h0, 32'h5A5A5A5A, 5'd4, 5'd4, 5'd4, 1'b1);
    check("wrap_zero", bus.retire_count, 32'h0);

    // Reset asserted on an edge carrying a write to reg 9.
    step(1'b1, 2'b10, 32'h0, 32'h99, 5'd9, 5'd9, 5'd9, 1'b1);
    step(1'b0, 2'b10, 32'h0, 32'hBEEF, 5'd9, 5'd9, 5'd9, 1'b1);
    rst_n = 1'b1;
    bus.mem_control_wb = 2'b00;
    #1;
    check("midrst_rs9", bus.rs_data, 32'h0);
    check("midrst_count", bus.retire_count, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, rs, rt;
      logic       rstn;
      wr   = 5'($urandom_range(0, 31));
      rs   = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rt   = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rstn = ($urandom_range(0, 49) != 0);
      step(rstn, 2'($urandom), $urandom, $urandom, wr, rs, rt, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
